// File: rtl/ring_ctr_pkg.sv
// Shared types and helpers for the ring/Johnson sequence generator.
// Pulled in with import ring_ctr_pkg::* by ring_johnson_ctr and ring_legal_chk.
package ring_ctr_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Home pattern, LSB-aligned in a 64-bit word; callers keep the low width bits.
  function automatic logic [63:0] home_pattern(mode_e mode, int width);
    return (mode == MODE_RING && width > 0) ? 64'd1 : 64'd0;
  endfunction

endpackage

// File: rtl/ring_legal_chk.sv
// Combinational legality check of a counter state for the given mode.
// Ring: exactly one bit set. Johnson: thermometer code, at most one adjacent-bit transition.
module ring_legal_chk
  import ring_ctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  mode_e            mode,
  output logic             legal
);

  logic [WIDTH-2:0] trans;

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_trans
    assign trans[gi] = state[gi] ^ state[gi+1];
  end

  always_comb begin
    legal = 1'b0;
    if (mode == MODE_RING) legal = ($countones(state) == 1);
    else                   legal = ($countones(trans) <= 1);
  end

endmodule

// File: rtl/ring_johnson_ctr.sv
// Ring / Johnson counter with direction, enable, parallel load and home wrap pulse.
// Define SELF_CORRECT_EN to force illegal states back to home on the next enabled step.
module ring_johnson_ctr
  import ring_ctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  mode_e            cur_mode;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] stepped;
  logic             fb_left, fb_right;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             wrap_reg, wrap_next;
  logic             err_reg, err_next;

  assign cur_mode = mode_e'(mode);
  assign home     = WIDTH'(home_pattern(cur_mode, WIDTH));

  // Johnson differs from ring only by inverting the bit fed back into the vacated end.
  assign fb_left  = (cur_mode == MODE_JOHNSON) ? ~out_reg[WIDTH-1] : out_reg[WIDTH-1];
  assign fb_right = (cur_mode == MODE_JOHNSON) ? ~out_reg[0]       : out_reg[0];
  assign stepped  = (dir == DIR_RIGHT) ? {fb_right, out_reg[WIDTH-1:1]}
                                       : {out_reg[WIDTH-2:0], fb_left};

`ifdef SELF_CORRECT_EN
  logic legal;

  ring_legal_chk #(.WIDTH(WIDTH)) u_legal (
    .state (out_reg),
    .mode  (cur_mode),
    .legal (legal)
  );
`endif

  always_comb begin
    out_next  = out_reg;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (load) begin
      out_next = load_val;
    end else if (en) begin
`ifdef SELF_CORRECT_EN
      if (!legal) begin
        out_next  = home;
        wrap_next = 1'b1;
        err_next  = 1'b1;
      end else begin
        out_next  = stepped;
        wrap_next = (stepped == home);
      end
`else
      out_next  = stepped;
      wrap_next = (stepped == home);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_reg  <= home;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      out_reg  <= out_next;
      wrap_reg <= wrap_next;
      err_reg  <= err_next;
    end
  end

  assign out  = out_reg;
  assign wrap = wrap_reg;
  assign err  = err_reg;

endmodule
